// File: rtl/host_loader.sv
// Byte-serial image loader: assembles 8-byte {address, data} frames from the host
// and issues one single-beat Wishbone write per frame, holding the CPU in reset until done.
//
// state    | meaning
// S_ADDR   | collecting the 4 little-endian address bytes
// S_DATA   | collecting the 4 little-endian data bytes
// S_WRITE  | Wishbone write in flight, waiting for ack/err/timeout
// S_FINISH | image complete, CPU released, absorbing until reset
module host_loader #(
    parameter int ADDR_SHIFT = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  hostctrl_data,
    input  logic        hostctrl_valid,
    output logic        hostctrl_ack,
    input  logic        hostctrl_done,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        cpu_rst_o,
    output logic        err_o,
    output logic [23:0] words_o
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_ADDR, S_DATA, S_WRITE, S_FINISH} state_t;

    state_t        state_q, state_n;
    logic [1:0]    idx_q, idx_n;
    logic [31:0]   addr_q, addr_n;
    logic [31:0]   data_q, data_n;
    logic          done_q, done_n;
    logic [TW-1:0] timer_q, timer_n;
    logic [31:0]   adr_n, dat_n;
    logic [3:0]    sel_n;
    logic          req_n, cpu_rst_n, err_n;
    logic [23:0]   words_n;
    logic          xfer;

    assign hostctrl_ack = (state_q == S_ADDR) || (state_q == S_DATA);
    assign xfer         = hostctrl_valid && hostctrl_ack;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_ADDR;
            idx_q     <= 2'd0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            done_q    <= 1'b0;
            timer_q   <= '0;
            wb_adr_o  <= 32'd0;
            wb_dat_o  <= 32'd0;
            wb_sel_o  <= 4'd0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            cpu_rst_o <= 1'b1;
            err_o     <= 1'b0;
            words_o   <= 24'd0;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            addr_q    <= addr_n;
            data_q    <= data_n;
            done_q    <= done_n;
            timer_q   <= timer_n;
            wb_adr_o  <= adr_n;
            wb_dat_o  <= dat_n;
            wb_sel_o  <= sel_n;
            wb_cyc_o  <= req_n;
            wb_stb_o  <= req_n;
            wb_we_o   <= req_n;
            cpu_rst_o <= cpu_rst_n;
            err_o     <= err_n;
            words_o   <= words_n;
        end
    end

    // Only single classic-cycle writes are ever issued.
    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        addr_n  = addr_q;
        data_n  = data_q;
        done_n  = done_q;
        timer_n = timer_q;
        adr_n   = wb_adr_o;
        dat_n   = wb_dat_o;
        sel_n   = wb_sel_o;
        req_n   = wb_cyc_o;
        err_n   = err_o;
        words_n = words_o;

        case (state_q)
            S_ADDR: begin
                if (hostctrl_done) begin
                    if (idx_q != 2'd0) err_n = 1'b1;
                    idx_n   = 2'd0;
                    state_n = S_FINISH;
                end else if (xfer) begin
                    addr_n[{idx_q, 3'b000} +: 8] = hostctrl_data;
                    idx_n = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (hostctrl_done) begin
                    err_n   = 1'b1;
                    idx_n   = 2'd0;
                    state_n = S_FINISH;
                end else if (xfer) begin
                    data_n[{idx_q, 3'b000} +: 8] = hostctrl_data;
                    idx_n = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_n = S_WRITE;
                        adr_n   = addr_q << ADDR_SHIFT;
                        dat_n   = data_n;
                        sel_n   = 4'hF;
                        req_n   = 1'b1;
                        timer_n = TW'(TIMEOUT);
                    end
                end
            end
            S_WRITE: begin
                if (hostctrl_done) done_n = 1'b1;
                // Timer loaded with TIMEOUT gives exactly TIMEOUT cycles of cyc high.
                if (wb_ack_i || wb_err_i || timer_q == TW'(1)) begin
                    req_n = 1'b0;
                    if (wb_ack_i) words_n = words_o + 24'd1;
                    else          err_n   = 1'b1;
                    state_n = (done_q || hostctrl_done) ? S_FINISH : S_ADDR;
                end else begin
                    timer_n = timer_q - TW'(1);
                end
            end
            default: ;
        endcase

        cpu_rst_n = (state_n != S_FINISH);
    end
endmodule
